// File: rtl/spi_master_if.sv
// -----------------------------------------------------------------------------
// spi_master_if
//   Control-side bus between on-chip logic and the spi_master frame engine.
//
//   start  : request one frame (honoured only while busy is low)
//   rw     : 1 = read, 0 = write; captured together with start
//   addr   : memory address; captured together with start
//   wdata  : write data; captured together with start, ignored on reads
//   busy   : frame in progress, including the trailing chip-select gap
//   done   : single-cycle pulse when the frame ends
//   rdata  : byte returned by the most recent completed read
//
//   modport master : the requesting control logic
//   modport slave  : the spi_master engine
// -----------------------------------------------------------------------------
interface spi_master_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output start, rw, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  start, rw, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   SPI mode-0 initiator for the spiMemory slave. One start pulse runs one
//   16-bit frame: 7 address bits (MSB first), a R/W bit (1 = read), then
//   8 data bits (MSB first). Reads transmit zeros in the data phase and
//   capture the slave's byte into rdata when the frame ends.
//
//   Ports:
//     clk       : system clock, shared with the memory; rising edge only
//     reset     : synchronous, active-high
//     bus       : control bus (spi_master_if.slave): start/rw/addr/wdata in,
//                 busy/done/rdata out
//     sclk_pin  : SPI clock, idles low
//     cs_pin    : chip select, active low, idles high
//     mosi_pin  : serial data to the slave, only changes while sclk is low
//     miso_pin  : serial data from the slave, already synchronous to clk
//
//   Timing, with N = CLKDIV and cycle 0 the cycle start is accepted:
//     cs low from cycle 1; SCLK rises at 1+N+2kN and falls at 1+2N+2kN
//     (k = 0..15); cs rises with done at 1+33N; busy drops at 1+34N.
//   CLKDIV must be >= 4 so the slave's conditioned MISO has settled before
//   each sampling edge.
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int CLKDIV     = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.slave  bus,
  output logic         sclk_pin,
  output logic         cs_pin,
  output logic         mosi_pin,
  input  logic         miso_pin
);

  localparam int FRAME_W = ADDR_WIDTH + 1 + DATA_WIDTH;
  localparam int DIV_W   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_W-1:0]    tx;
  logic [DATA_WIDTH-1:0] rx;
  logic                  rw_q;

  // Frame as it would be captured this cycle; a read carries zero data bits.
  logic [FRAME_W-1:0] frame_in;
  assign frame_in = {bus.addr, bus.rw, (bus.rw ? {DATA_WIDTH{1'b0}} : bus.wdata)};

  // tx holds only the bits still to be sent, left-aligned: the MSB goes
  // straight onto mosi_pin when the frame is accepted, so each falling SCLK
  // edge presents tx[MSB] and shifts the remainder up.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: tx/rx are cleared too even though a frame always reloads them;
      // it keeps the shift registers free of X and costs nothing here.
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx        <= '0;
      rx        <= '0;
      rw_q      <= 1'b0;
      sclk_pin  <= 1'b0;
      cs_pin    <= 1'b1;
      mosi_pin  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.rdata <= '0;
    end else begin
      // NOTE: every state update uses non-blocking assignment so all
      // registers see the values from before this edge; done defaults low
      // here, which makes it a single-cycle pulse.
      bus.done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            tx       <= {frame_in[FRAME_W-2:0], 1'b0};
            mosi_pin <= frame_in[FRAME_W-1];
            rw_q     <= bus.rw;
            cs_pin   <= 1'b0;
            bus.busy <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= SETUP;
          end
        end

        // SCLK low for one half-period so the first MOSI bit is set up.
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            sclk_pin <= 1'b1;
            rx       <= {rx[DATA_WIDTH-2:0], miso_pin};
            state    <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        // Each half-period ends in an SCLK edge: rising samples MISO,
        // falling advances MOSI or, after the last bit, leaves for HOLD.
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (sclk_pin) begin
              sclk_pin <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                mosi_pin <= 1'b0;
                state    <= HOLD;
              end else begin
                mosi_pin <= tx[FRAME_W-1];
                tx       <= {tx[FRAME_W-2:0], 1'b0};
                bit_cnt  <= bit_cnt + BIT_W'(1);
              end
            end else begin
              sclk_pin <= 1'b1;
              rx       <= {rx[DATA_WIDTH-2:0], miso_pin};
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        // cs held low one half-period after the last fall, then released.
        HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            cs_pin   <= 1'b1;
            bus.done <= 1'b1;
            if (rw_q) begin
              bus.rdata <= rx;
            end
            state <= GAP;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        // Minimum cs-high time before another frame can be accepted.
        GAP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Drives spi_master (CLKDIV = 4) against a behavioural spiMemory-style
//   slave. A frame-level reference model predicts every pin and bus output
//   from the cycle offset since acceptance; one compare process checks them
//   on every cycle. Directed scenarios pin the model with hand-computed
//   literals, then randomized frames follow.
// -----------------------------------------------------------------------------
module tb_spi_master;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  logic sclk_pin, cs_pin, mosi_pin, miso_pin;

  spi_master_if bus ();

  spi_master #(.CLKDIV(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .sclk_pin (sclk_pin),
    .cs_pin   (cs_pin),
    .mosi_pin (mosi_pin),
    .miso_pin (miso_pin)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural slave: shifts MOSI on SCLK rise, drives MISO on SCLK fall,
  // commits a write only when a full 16-rise frame ends with cs rising.
  // ---------------------------------------------------------------------------
  logic [7:0]  sl_mem [128];
  logic [15:0] sl_shift = '0;
  logic [15:0] sl_last  = '0;
  logic [7:0]  sl_byte  = '0;
  int          sl_rises = 0;
  int          sl_falls = 0;
  bit          sl_rd    = 1'b0;
  bit          sl_sclk_q = 1'b0;
  bit          sl_cs_q   = 1'b1;

  always @(posedge clk) begin
    if (cs_pin === 1'b1) begin
      if (!sl_cs_q && sl_rises == 16) begin
        sl_last = sl_shift;
        if (!sl_shift[8]) sl_mem[sl_shift[15:9]] = sl_shift[7:0];
      end
      sl_rises = 0;
      sl_falls = 0;
      sl_rd    = 1'b0;
      miso_pin <= 1'b0;
    end else if (cs_pin === 1'b0) begin
      if (sclk_pin && !sl_sclk_q) begin
        sl_shift = {sl_shift[14:0], mosi_pin};
        sl_rises++;
      end
      if (!sclk_pin && sl_sclk_q) begin
        sl_falls++;
        if (sl_falls == 8) begin
          sl_rd   = sl_shift[0];
          sl_byte = sl_mem[sl_shift[7:1]];
        end
        if (sl_rd && sl_falls >= 8 && sl_falls <= 15) miso_pin <= sl_byte[15 - sl_falls];
        else                                          miso_pin <= 1'b0;
      end
    end
    sl_sclk_q = (sclk_pin === 1'b1);
    sl_cs_q   = (cs_pin !== 1'b0);
  end

  // ---------------------------------------------------------------------------
  // Reference model: remembers the accepted frame and its acceptance cycle;
  // all outputs follow from the offset rel = cycle - t0.
  // ---------------------------------------------------------------------------
  int         cyc = 0;
  int         t0  = 0;
  bit         started  = 1'b0;
  bit         m_active = 1'b0;
  bit         m_rw     = 1'b0;
  logic [6:0] m_addr   = '0;
  logic [7:0] m_wdata  = '0;
  logic [7:0] m_rdata  = '0;
  logic [7:0] m_mem [128];

  function automatic bit m_busy(input int c);
    return m_active && (c - t0) >= 1 && (c - t0) <= 34 * N;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_rdata  = '0;
      started  = 1'b1;
    end else begin
      if (m_active && (cyc + 1 - t0) == 1 + 33 * N) begin
        if (m_rw) m_rdata = m_mem[m_addr];
        else      m_mem[m_addr] = m_wdata;
      end
      if (!m_busy(cyc) && bus.start) begin
        t0       = cyc;
        m_active = 1'b1;
        m_rw     = bus.rw;
        m_addr   = bus.addr;
        m_wdata  = bus.wdata;
      end
    end
    cyc++;
  end

  int          rel;
  logic [15:0] fr;
  logic [12:0] exp_v;
  logic [12:0] act_v;

  always @(negedge clk) begin
    if (started) begin
      rel       = cyc - t0;
      fr        = {m_addr, m_rw, (m_rw ? 8'h00 : m_wdata)};
      exp_v[12] = !(m_active && rel >= 1 && rel <= 33 * N);
      exp_v[11] = m_active && rel >= 1 + N && rel < 1 + 32 * N && ((rel - 1 - N) % (2 * N)) < N;
      exp_v[10] = (m_active && rel >= 1 && rel < 1 + 32 * N) ? fr[15 - (rel - 1) / (2 * N)] : 1'b0;
      exp_v[9]  = m_busy(cyc);
      exp_v[8]  = m_active && rel == 1 + 33 * N;
      exp_v[7:0] = m_rdata;
      act_v = {cs_pin, sclk_pin, mosi_pin, bus.busy, bus.done, bus.rdata};
      check($sformatf("pins cyc=%0d rel=%0d {cs,sclk,mosi,busy,done,rdata}", cyc, rel), act_v, exp_v);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  typedef struct {
    int          cs_fall;
    int          cs_rise;
    int          cs_fall2;
    int          done_rel;
    int          dones;
    int          busy_fall;
    int          rises;
    int          rises_first;
    logic [11:0] after_rst;
  } obs_t;

  // Waits (bounded) for busy low, then presents a request in that cycle.
  task automatic launch(input bit rw, input logic [6:0] a, input logic [7:0] d);
    for (int i = 0; i < 40 * N; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) break;
    end
    check("launch_wait_busy_low", bus.busy, 1'b0);
    bus.start = 1'b1;
    bus.rw    = rw;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  // Runs ncyc cycles after the launch cycle, recording edges relative to it.
  // pa/pb: cycles with extra start pulses; rst_at: reset cycle (0 = none).
  task automatic run_obs(input int pa, input int pb, input int rst_at, input bit hold,
                         input int ncyc, output obs_t o);
    bit p_cs   = 1'b1;
    bit p_sclk = 1'b0;
    bit p_busy = 1'b0;
    o.cs_fall = -1; o.cs_rise = -1; o.cs_fall2 = -1; o.done_rel = -1;
    o.dones = 0; o.busy_fall = -1; o.rises = 0; o.rises_first = 0; o.after_rst = '0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (!cs_pin && p_cs) begin
        if (o.cs_fall < 0) o.cs_fall = i;
        else if (o.cs_fall2 < 0) o.cs_fall2 = i;
      end
      if (cs_pin && !p_cs && o.cs_rise < 0) o.cs_rise = i;
      if (sclk_pin && !p_sclk) begin
        o.rises++;
        if (o.cs_rise < 0) o.rises_first++;
      end
      if (bus.done) begin
        o.dones++;
        if (o.done_rel < 0) o.done_rel = i;
      end
      if (!bus.busy && p_busy && o.busy_fall < 0) o.busy_fall = i;
      if (rst_at > 0 && i == rst_at + 1) o.after_rst = {cs_pin, sclk_pin, mosi_pin, bus.busy, bus.rdata};
      p_cs   = cs_pin;
      p_sclk = sclk_pin;
      p_busy = bus.busy;
      bus.start = hold || (i == pa) || (i == pb);
      reset     = (rst_at > 0) && (i == rst_at);
    end
    bus.start = 1'b0;
    reset     = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  obs_t o;
  int   rst_at;
  int   pa;

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.rw    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    for (int i = 0; i < 128; i++) begin
      sl_mem[i] = 8'($urandom);
      m_mem[i]  = sl_mem[i];
    end
    repeat (3) @(negedge clk);
    check("reset_state {cs,sclk,mosi,busy,done,rdata}",
          {cs_pin, sclk_pin, mosi_pin, bus.busy, bus.done, bus.rdata}, 13'h1000);
    reset = 1'b0;

    // Write 0x14 <- 0xC5.
    launch(1'b0, 7'h14, 8'hC5);
    run_obs(0, 0, 0, 1'b0, 150, o);
    check("wr_cs_fall",   o.cs_fall,   1);
    check("wr_cs_rise",   o.cs_rise,   133);
    check("wr_done_cyc",  o.done_rel,  133);
    check("wr_done_cnt",  o.dones,     1);
    check("wr_busy_fall", o.busy_fall, 137);
    check("wr_rises",     o.rises,     16);
    check("wr_mosi_bits", sl_last,     16'h28C5);
    check("wr_rdata",     bus.rdata,   8'h00);

    // Read 0x14 from a slave holding 0xA5; wdata must not leak onto MOSI.
    sl_mem[7'h14] = 8'hA5;
    m_mem[7'h14]  = 8'hA5;
    launch(1'b1, 7'h14, 8'h5A);
    run_obs(0, 0, 0, 1'b0, 150, o);
    check("rd_done_cnt",  o.dones,   1);
    check("rd_mosi_bits", sl_last,   16'h2900);
    check("rd_rdata",     bus.rdata, 8'hA5);

    // Extra start pulses inside a frame are ignored.
    launch(1'b0, 7'h33, 8'h6E);
    run_obs(10, 60, 0, 1'b0, 150, o);
    check("ign_rises",    o.rises,    16);
    check("ign_done_cnt", o.dones,    1);
    check("ign_no_2nd",   o.cs_fall2, -1);

    // Reset at cycle 50 aborts the frame; rdata returns to 0, no done.
    launch(1'b0, 7'h22, 8'h99);
    run_obs(0, 0, 50, 1'b0, 150, o);
    check("rst_pins {cs,sclk,mosi,busy,rdata}", o.after_rst, 12'h800);
    check("rst_done_cnt", o.dones, 0);
    launch(1'b0, 7'h22, 8'h99);
    run_obs(0, 0, 0, 1'b0, 150, o);
    check("post_rst_done_cyc", o.done_rel, 133);
    check("post_rst_done_cnt", o.dones,    1);

    // start held high: frames run back to back with the cs gap.
    launch(1'b0, 7'h01, 8'h42);
    run_obs(0, 0, 0, 1'b1, 270, o);
    check("b2b_rises_first", o.rises_first, 16);
    check("b2b_rises_total", o.rises,       32);
    check("b2b_cs_fall2",    o.cs_fall2,    138);
    check("b2b_gap_ge_N",    (o.cs_fall2 - o.cs_rise) >= N, 1'b1);

    // Write then read back through the slave memory.
    launch(1'b0, 7'h05, 8'h3C);
    run_obs(0, 0, 0, 1'b0, 150, o);
    launch(1'b1, 7'h05, 8'h00);
    run_obs(0, 0, 0, 1'b0, 150, o);
    check("wr_rd_05", bus.rdata, 8'h3C);

    // Randomized frames on a small address set so reads hit earlier writes.
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      pa     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 140)) : 0;
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 130)) : 0;
      launch(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom));
      run_obs(pa, 0, rst_at, 1'b0, 140, o);
      check($sformatf("rand%0d_done_cnt", t), o.dones, (rst_at > 0) ? 0 : 1);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
